// File: rtl/ecc_scrubber_if.sv
// Host-side bus between the ECC scrubber and the memory/control agent.
// Optional error-log signals exist only when ECC_SCRUB_ERRLOG_EN is defined.
interface ecc_scrubber_if #(
   parameter int unsigned ADDR_W = 4
) ();
   logic              start;
   logic              busy;
   logic              done;
   logic              mem_grant;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [11:0]       mem_rd_data;
   logic              mem_wr_en;
   logic [11:0]       mem_wr_data;
   logic [7:0]        corr_count;
   logic [7:0]        uncorr_count;
`ifdef ECC_SCRUB_ERRLOG_EN
   logic [ADDR_W-1:0] err_addr;
   logic              err_valid;

   modport master (
      input  start, mem_grant, mem_rd_data,
      output busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      output corr_count, uncorr_count, err_addr, err_valid
   );

   modport slave (
      output start, mem_grant, mem_rd_data,
      input  busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      input  corr_count, uncorr_count, err_addr, err_valid
   );
`else
   modport master (
      input  start, mem_grant, mem_rd_data,
      output busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      output corr_count, uncorr_count
   );

   modport slave (
      output start, mem_grant, mem_rd_data,
      input  busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
      input  corr_count, uncorr_count
   );
`endif
endinterface

// File: rtl/ecc_scrubber.sv
// Hamming(12,8) memory scrubber: reads every word once per pass, writes back single-bit fixes.
// Optional first-error log per pass is enabled by defining ECC_SCRUB_ERRLOG_EN.
module ecc_scrubber #(
   parameter int unsigned ADDR_W = 4
) (
   input logic            clk,
   input logic            rst,
   ecc_scrubber_if.master bus
);

   localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StWait,
      StCheck,
      StWrite,
      StNext,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [11:0]       rdata_q, rdata_d;
   logic [11:0]       wdata_q, wdata_d;
   logic [7:0]        corr_q, corr_d;
   logic [7:0]        uncorr_q, uncorr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef ECC_SCRUB_ERRLOG_EN
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              err_valid_q, err_valid_d;
`endif

   logic [3:0]  syndrome;
   logic [11:0] corrected;

   // Each syndrome bit covers the codeword positions whose index has that bit set.
   always_comb begin
      syndrome[0] = ^(rdata_q & 12'h555);
      syndrome[1] = ^(rdata_q & 12'h666);
      syndrome[2] = ^(rdata_q & 12'h878);
      syndrome[3] = ^(rdata_q & 12'hF80);
      corrected   = rdata_q ^ (12'd1 << (syndrome - 4'd1));
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rdata_d  = rdata_q;
      wdata_d  = wdata_q;
      corr_d   = corr_q;
      uncorr_d = uncorr_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef ECC_SCRUB_ERRLOG_EN
      err_addr_d  = err_addr_q;
      err_valid_d = err_valid_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               addr_d   = '0;
               corr_d   = '0;
               uncorr_d = '0;
               busy_d   = 1'b1;
               state_d  = StRead;
`ifdef ECC_SCRUB_ERRLOG_EN
               err_valid_d = 1'b0;
`endif
            end
         end
         StRead: begin
            if (bus.mem_grant) state_d = StWait;
         end
         StWait: begin
            rdata_d = bus.mem_rd_data;
            state_d = StCheck;
         end
         StCheck: begin
            if (syndrome == 4'd0) begin
               state_d = StNext;
            end else if (syndrome <= 4'd12) begin
               wdata_d = corrected;
               corr_d  = (corr_q != 8'hFF) ? corr_q + 8'd1 : corr_q;
               state_d = StWrite;
            end else begin
               uncorr_d = (uncorr_q != 8'hFF) ? uncorr_q + 8'd1 : uncorr_q;
               state_d  = StNext;
            end
`ifdef ECC_SCRUB_ERRLOG_EN
            if (syndrome != 4'd0 && !err_valid_q) begin
               err_addr_d  = addr_q;
               err_valid_d = 1'b1;
            end
`endif
         end
         StWrite: begin
            if (bus.mem_grant) state_d = StNext;
         end
         StNext: begin
            if (addr_q == LastAddr) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = StRead;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         rdata_q  <= '0;
         wdata_q  <= '0;
         corr_q   <= '0;
         uncorr_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef ECC_SCRUB_ERRLOG_EN
         err_addr_q  <= '0;
         err_valid_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rdata_q  <= rdata_d;
         wdata_q  <= wdata_d;
         corr_q   <= corr_d;
         uncorr_q <= uncorr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef ECC_SCRUB_ERRLOG_EN
         err_addr_q  <= err_addr_d;
         err_valid_q <= err_valid_d;
`endif
      end
   end

   // Strobes follow grant combinationally so a denied cycle issues no access.
   assign bus.mem_rd_en    = (state_q == StRead) & bus.mem_grant;
   assign bus.mem_wr_en    = (state_q == StWrite) & bus.mem_grant;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wr_data  = wdata_q;
   assign bus.corr_count   = corr_q;
   assign bus.uncorr_count = uncorr_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
`ifdef ECC_SCRUB_ERRLOG_EN
   assign bus.err_addr  = err_addr_q;
   assign bus.err_valid = err_valid_q;
`endif

endmodule

// File: tb/tb_ecc_scrubber.sv
// Self-checking bench for ecc_scrubber: directed and randomized passes against a memory model.
// Error-log checks are compiled in when ECC_SCRUB_ERRLOG_EN is defined.
module tb_ecc_scrubber;

   localparam int unsigned AW    = 4;
   localparam int          Depth = 16;
   localparam int          Limit = 3000;

   logic clk;
   logic rst;

   ecc_scrubber_if #(.ADDR_W(AW)) bus ();

   ecc_scrubber #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [11:0] mem [Depth];
   logic [11:0] img [Depth];
   logic [11:0] exp_mem [Depth];
   logic        load_req;

   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          both_cnt = 0;
   logic [AW-1:0] last_wr_addr;
   logic [11:0]   last_wr_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: registered read data, one cycle after an accepted read.
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < Depth; i++) mem[i] <= img[i];
      end else if (bus.mem_wr_en) begin
         mem[bus.mem_addr] <= bus.mem_wr_data;
      end
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
      if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
      if (bus.mem_wr_en) begin
         wr_cnt       <= wr_cnt + 1;
         last_wr_addr <= bus.mem_addr;
         last_wr_data <= bus.mem_wr_data;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.mem_rd_en && bus.mem_wr_en) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] encode(input logic [7:0] d);
      int          dpos [8];
      logic [11:0] w;
      logic        par;
      int          p;
      dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
      w = '0;
      for (int i = 0; i < 8; i++) w[dpos[i]-1] = d[i];
      for (int k = 0; k < 4; k++) begin
         p   = 1 << k;
         par = 1'b0;
         for (int pos = 1; pos <= 12; pos++)
            if ((pos & p) != 0 && pos != p) par = par ^ w[pos-1];
         w[p-1] = par;
      end
      return w;
   endfunction

   function automatic int syn_of(input logic [11:0] w);
      int s = 0;
      for (int pos = 1; pos <= 12; pos++) if (w[pos-1]) s = s ^ pos;
      return s;
   endfunction

   function automatic logic [11:0] fix_of(input logic [11:0] w);
      int          s;
      logic [11:0] r;
      s = syn_of(w);
      r = w;
      if (s >= 1 && s <= 12) r[s-1] = ~r[s-1];
      return r;
   endfunction

   task automatic load_mem();
      load_req = 1'b1;
      @(posedge clk);
      #1 load_req = 1'b0;
   endtask

   task automatic fill_clean();
      for (int i = 0; i < Depth; i++) img[i] = encode(8'($urandom_range(0, 255)));
   endtask

   task automatic run_pass(input int stall_addr, input int stall_len, input bit rnd,
                           output int cyc);
      int left;
      bit stalled;
      left    = 0;
      stalled = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = 1;
      check("pass_start_addr", 32'(bus.mem_addr), 0);
      check("pass_busy", 32'(bus.busy), 1);
      while (!bus.done && cyc < Limit) begin
         if (stall_addr >= 0 && !stalled && int'(bus.mem_addr) == stall_addr) begin
            stalled = 1'b1;
            left    = stall_len;
         end
         if (left > 0) begin
            bus.mem_grant = 1'b0;
            left--;
            #1;
            check("stall_rd_en", 32'(bus.mem_rd_en), 0);
            check("stall_wr_en", 32'(bus.mem_wr_en), 0);
            check("stall_addr", 32'(bus.mem_addr), 32'(stall_addr));
         end else begin
            bus.mem_grant = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         @(posedge clk);
         #1 cyc++;
      end
      check("pass_timeout", 32'(cyc < Limit), 1);
      check("done_busy_low", 32'(bus.busy), 0);
      bus.mem_grant = 1'b1;
      @(posedge clk);
      #1 check("done_one_cycle", 32'(bus.done), 0);
   endtask

   int cyc, r0, w0, d0, n, b1, b2, flips, s;
   int exp_corr, exp_unc, first_err;
   logic [11:0] w;

   initial begin
      rst           = 1'b1;
      load_req      = 1'b0;
      bus.start     = 1'b0;
      bus.mem_grant = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_rd_en", 32'(bus.mem_rd_en), 0);
      check("rst_wr_en", 32'(bus.mem_wr_en), 0);
      check("rst_addr", 32'(bus.mem_addr), 0);
      check("rst_corr", 32'(bus.corr_count), 0);
      check("rst_uncorr", 32'(bus.uncorr_count), 0);
`ifdef ECC_SCRUB_ERRLOG_EN
      check("rst_err_valid", 32'(bus.err_valid), 0);
      check("rst_err_addr", 32'(bus.err_addr), 0);
`endif
      rst = 1'b0;

      // Clean memory, full grant.
      fill_clean();
      load_mem();
      r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
      run_pass(-1, 0, 1'b0, cyc);
      check("clean_cycles", 32'(cyc), 65);
      check("clean_reads", 32'(rd_cnt - r0), 16);
      check("clean_writes", 32'(wr_cnt - w0), 0);
      check("clean_done_pulses", 32'(done_cnt - d0), 1);
      check("clean_corr", 32'(bus.corr_count), 0);
      check("clean_uncorr", 32'(bus.uncorr_count), 0);
      for (int i = 0; i < Depth; i++) check("clean_mem", 32'(mem[i]), 32'(img[i]));

      // Single-bit error at address 5.
      fill_clean();
      img[5] = encode(8'hA5) ^ 12'h004;
      load_mem();
      r0 = rd_cnt; w0 = wr_cnt;
      run_pass(-1, 0, 1'b0, cyc);
      check("single_cycles", 32'(cyc), 66);
      check("single_writes", 32'(wr_cnt - w0), 1);
      check("single_wr_addr", 32'(last_wr_addr), 5);
      check("single_wr_data", 32'(last_wr_data), 32'(encode(8'hA5)));
      check("single_corr", 32'(bus.corr_count), 1);
      check("single_uncorr", 32'(bus.uncorr_count), 0);
      check("single_mem5", 32'(mem[5]), 32'(encode(8'hA5)));

      // Double-bit error at address 9 (syndrome 13).
      fill_clean();
      img[9] = img[9] ^ 12'h801;
      load_mem();
      w0 = wr_cnt;
      run_pass(-1, 0, 1'b0, cyc);
      check("double_writes", 32'(wr_cnt - w0), 0);
      check("double_uncorr", 32'(bus.uncorr_count), 1);
      check("double_corr", 32'(bus.corr_count), 0);
`ifdef ECC_SCRUB_ERRLOG_EN
      check("double_err_addr", 32'(bus.err_addr), 9);
      check("double_err_valid", 32'(bus.err_valid), 1);
`endif

      // Grant withheld for 10 cycles in READ at address 3.
      fill_clean();
      load_mem();
      r0 = rd_cnt; w0 = wr_cnt;
      run_pass(3, 10, 1'b0, cyc);
      check("stall_cycles", 32'(cyc), 75);
      check("stall_reads", 32'(rd_cnt - r0), 16);
      check("stall_writes", 32'(wr_cnt - w0), 0);
      check("stall_corr", 32'(bus.corr_count), 0);
      check("stall_uncorr", 32'(bus.uncorr_count), 0);

      // Randomized corruption with random grant.
      for (int t = 0; t < 4; t++) begin
         exp_corr = 0; exp_unc = 0; first_err = -1;
         for (int i = 0; i < Depth; i++) begin
            w     = encode(8'($urandom_range(0, 255)));
            flips = $urandom_range(0, 2);
            b1    = $urandom_range(0, 11);
            b2    = (b1 + 1 + $urandom_range(0, 10)) % 12;
            if (flips >= 1) w[b1] = ~w[b1];
            if (flips == 2) w[b2] = ~w[b2];
            img[i]     = w;
            exp_mem[i] = fix_of(w);
            s          = syn_of(w);
            if (s != 0 && first_err < 0) first_err = i;
            if (s >= 1 && s <= 12) exp_corr++;
            else if (s > 12) exp_unc++;
         end
         load_mem();
         r0 = rd_cnt; w0 = wr_cnt;
         run_pass(-1, 0, 1'b1, cyc);
         check("rand_reads", 32'(rd_cnt - r0), 16);
         check("rand_writes", 32'(wr_cnt - w0), 32'(exp_corr));
         check("rand_corr", 32'(bus.corr_count), 32'(exp_corr));
         check("rand_uncorr", 32'(bus.uncorr_count), 32'(exp_unc));
         for (int i = 0; i < Depth; i++) check("rand_mem", 32'(mem[i]), 32'(exp_mem[i]));
`ifdef ECC_SCRUB_ERRLOG_EN
         check("rand_err_valid", 32'(bus.err_valid), 32'(first_err >= 0));
         if (first_err >= 0) check("rand_err_addr", 32'(bus.err_addr), 32'(first_err));
`endif
      end

      // Asynchronous reset in the middle of a pass.
      fill_clean();
      load_mem();
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      while (int'(bus.mem_addr) != 7 && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      check("reach_addr7", 32'(n < 200), 1);
      r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_done", 32'(bus.done), 0);
      check("arst_rd_en", 32'(bus.mem_rd_en), 0);
      check("arst_wr_en", 32'(bus.mem_wr_en), 0);
      check("arst_addr", 32'(bus.mem_addr), 0);
      check("arst_counts", 32'({bus.corr_count, bus.uncorr_count}), 0);
      check("arst_wr_data", 32'(bus.mem_wr_data), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("arst_no_done", 32'(done_cnt - d0), 0);
      check("arst_no_reads", 32'(rd_cnt - r0), 0);
      check("arst_no_writes", 32'(wr_cnt - w0), 0);
      check("arst_idle", 32'(bus.busy), 0);
      r0 = rd_cnt;
      run_pass(-1, 0, 1'b0, cyc);
      check("rescan_cycles", 32'(cyc), 65);
      check("rescan_reads", 32'(rd_cnt - r0), 16);

      // Every word single-bit-error, many passes: counters restart each pass.
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < Depth; i++) begin
            w          = encode(8'($urandom_range(0, 255)));
            exp_mem[i] = w;
            b1         = $urandom_range(0, 11);
            w[b1]      = ~w[b1];
            img[i]     = w;
         end
         load_mem();
         w0 = wr_cnt;
         run_pass(-1, 0, 1'b0, cyc);
         check("multi_corr", 32'(bus.corr_count), 16);
         check("multi_uncorr", 32'(bus.uncorr_count), 0);
         check("multi_writes", 32'(wr_cnt - w0), 16);
         check("multi_cycles", 32'(cyc), 81);
         for (int i = 0; i < Depth; i++) check("multi_mem", 32'(mem[i]), 32'(exp_mem[i]));
      end

      // start while busy must not restart the pass.
      fill_clean();
      load_mem();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      r0 = rd_cnt;
      repeat (20) @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < Limit) begin
         @(posedge clk);
         #1 n++;
      end
      check("busy_start_ignored_len", 32'(n), 44);
      check("busy_start_reads", 32'(rd_cnt - r0), 16);

      check("rd_wr_exclusive", 32'(both_cnt), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
